// File: rtl/accu_beat_splitter_if.sv
// Handshake bundle between the word source, the beat splitter and the
// downstream accumulator.
//   word_in / word_vld / word_rdy : packed-word handshake (upstream side)
//   data_out / valid_out / ready_out : beat stream handshake (downstream side)
//   beat_idx / last_out / sum_out : beat position, end-of-group flag, group sum
// Modport master is the splitter; modport slave is its environment.
interface accu_beat_splitter_if #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 8,
    parameter int SUM_W  = 10
);
    localparam int IDX_W  = $clog2(BEATS);
    localparam int WORD_W = BEATS * BEAT_W;

    logic [WORD_W-1:0] word_in;
    logic              word_vld;
    logic              word_rdy;
    logic [BEAT_W-1:0] data_out;
    logic              valid_out;
    logic              ready_out;
    logic [IDX_W-1:0]  beat_idx;
    logic              last_out;
    logic [SUM_W-1:0]  sum_out;

    modport master (
        input  word_in, word_vld, ready_out,
        output word_rdy, data_out, valid_out, beat_idx, last_out, sum_out
    );

    modport slave (
        output word_in, word_vld, ready_out,
        input  word_rdy, data_out, valid_out, beat_idx, last_out, sum_out
    );
endinterface

// File: rtl/accu_beat_splitter.sv
// Transmit side of the 4-beat accumulate protocol: takes one packed word of
// BEATS x BEAT_W bits per handshake and emits it as BEATS beats, LSB beat
// first, with valid/ready flow control. The group sum is registered with the
// word capture and held for the whole group as a reference for downstream.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : accu_beat_splitter_if.master (word handshake in, beat stream out)
// All outputs are registered except word_rdy, which combinationally follows
// ready_out so a new word can be taken on the last beat with no bubble.
module accu_beat_splitter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 8,
    parameter int SUM_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    accu_beat_splitter_if.master    bus
);
    localparam int IDX_W  = $clog2(BEATS);
    localparam int WORD_W = BEATS * BEAT_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [BEAT_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;
    logic              valid_q, valid_d;
    logic [SUM_W-1:0]  sum_q,   sum_d;

    logic              word_rdy;
    logic              accept;
    logic              xfer;
    logic [IDX_W-1:0]  nxt_idx;

    function automatic logic [SUM_W-1:0] group_sum(input logic [WORD_W-1:0] w);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            acc = acc + SUM_W'(w[k*BEAT_W +: BEAT_W]);
        end
        return acc;
    endfunction

    // last_q is only ever set in SEND, so it stands in for "SEND & last beat".
    assign word_rdy = !rst && ((state_q == IDLE) || (last_q && bus.ready_out));
    assign accept   = word_rdy && bus.word_vld;
    assign xfer     = valid_q && bus.ready_out;
    assign nxt_idx  = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && !last_q) begin
                    idx_d  = nxt_idx;
                    data_d = word_q[int'(nxt_idx)*BEAT_W +: BEAT_W];
                    last_d = (nxt_idx == IDX_W'(BEATS-1));
                end else if (xfer && !accept) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture is shared by IDLE and by the back-to-back case on the last beat.
        if (accept) begin
            state_d = SEND;
            word_d  = bus.word_in;
            sum_d   = group_sum(bus.word_in);
            idx_d   = '0;
            data_d  = bus.word_in[BEAT_W-1:0];
            last_d  = 1'b0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.word_rdy  = word_rdy;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.beat_idx  = idx_q;
    assign bus.last_out  = last_q;
    assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_accu_beat_splitter.sv
// Scoreboard bench for accu_beat_splitter (BEATS=4, BEAT_W=8, SUM_W=10).
// Accepted words are expanded into expected beats in a queue; every beat the
// DUT presents is compared with the queue head and popped on transfer.
module tb_accu_beat_splitter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accu_beat_splitter_if #(.BEATS(4), .BEAT_W(8), .SUM_W(10)) bus ();

    accu_beat_splitter #(.BEATS(4), .BEAT_W(8), .SUM_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
        logic [9:0] sum;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   accepts = 0;
    int   groups  = 0;
    int   acc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_sum(input logic [31:0] w);
        logic [9:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + {2'b00, w[k*8 +: 8]};
        return s;
    endfunction

    // Monitor / scoreboard: inputs change at posedge+1, so negedge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            acc = 0;
        end else begin
            check("valid", bus.valid_out, q.size() != 0);
            check("word_rdy", bus.word_rdy, (q.size() == 0) || (q.size() == 1 && bus.ready_out));
            if (bus.valid_out && q.size() != 0) begin
                e = q[0];
                check("data", bus.data_out, e.data);
                check("beat_idx", bus.beat_idx, e.idx);
                check("last", bus.last_out, e.last);
                check("sum", bus.sum_out, e.sum);
                if (bus.ready_out) begin
                    void'(q.pop_front());
                    acc = acc + int'(bus.data_out);
                    if (e.last) begin
                        check("grp_sum", acc, e.sum);
                        acc = 0;
                        groups++;
                    end
                end
            end
            if (bus.word_rdy && bus.word_vld) begin
                accepts++;
                for (int k = 0; k < 4; k++) begin
                    e.data = bus.word_in[k*8 +: 8];
                    e.idx  = 2'(k);
                    e.last = (k == 3);
                    e.sum  = model_sum(bus.word_in);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        bus.word_in  = w;
        bus.word_vld = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.word_rdy && n < 200);
        if (n >= 200) check("send_timeout", 1, 0);
        @(posedge clk); #1;
        bus.word_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.valid_out) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;
        int cycles;
        int prev_acc;
        int g0;

        bus.word_in   = '0;
        bus.word_vld  = 1'b0;
        bus.ready_out = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_valid", bus.valid_out, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_idx", bus.beat_idx, 0);
        check("rst_last", bus.last_out, 0);
        check("rst_sum", bus.sum_out, 0);
        check("rst_rdy", bus.word_rdy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: single word, ready always high
        bus.ready_out = 1'b1;
        send_word(32'h04030201);
        @(negedge clk);
        check("t1_sum", bus.sum_out, 10'h00A);
        check("t1_first", bus.data_out, 8'h01);
        wait_idle();

        // 2: ready low on SEND cycles 2 and 3
        send_word(32'h04030201);
        @(posedge clk); #1 bus.ready_out = 1'b0;
        @(negedge clk);
        check("t2_hold", bus.data_out, 8'h02);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_hold2", bus.data_out, 8'h02);
        @(posedge clk); #1 bus.ready_out = 1'b1;
        wait_idle();

        // 3: back-to-back words
        send_word(32'hFFFFFFFF);
        @(negedge clk);
        check("t3_sum_a", bus.sum_out, 10'h3FC);
        send_word(32'h00000001);
        @(negedge clk);
        check("t3_sum_b", bus.sum_out, 10'h001);
        wait_idle();

        // 4: word offered mid-group is held off until the last beat
        send_word(32'h44332211);
        bus.word_in  = 32'h88776655;
        bus.word_vld = 1'b1;
        @(negedge clk);
        check("t4_rdy_low", bus.word_rdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_rdy_low2", bus.word_rdy, 0);
        send_word(32'h88776655);
        wait_idle();

        // 5: reset in the middle of a group
        send_word(32'hA0B0C0D0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_valid", bus.valid_out, 0);
        check("t5_sum", bus.sum_out, 0);
        check("t5_idx", bus.beat_idx, 0);
        check("t5_rdy", bus.word_rdy, 0);
        @(posedge clk); #1 rst = 1'b0;
        send_word(32'h11223344);
        @(negedge clk);
        check("t5_first", bus.data_out, 8'h44);
        check("t5_first_idx", bus.beat_idx, 0);
        wait_idle();

        // 6: random words, random ready, 1000 groups
        g0       = groups;
        sent     = 0;
        cycles   = 0;
        prev_acc = accepts;
        while (sent < 1000 && cycles < 20000) begin
            @(posedge clk); #1;
            cycles++;
            bus.ready_out = ($urandom_range(0, 3) != 0);
            if (bus.word_vld && accepts != prev_acc) begin
                bus.word_vld = 1'b0;
                sent++;
            end
            prev_acc = accepts;
            if (!bus.word_vld && sent < 1000 && $urandom_range(0, 2) != 0) begin
                bus.word_in  = $urandom;
                bus.word_vld = 1'b1;
            end
        end
        if (sent < 1000) check("t6_timeout", sent, 1000);
        bus.word_vld  = 1'b0;
        bus.ready_out = 1'b1;
        wait_idle();
        check("t6_groups", groups - g0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
